sd_crc_lanes: RTL and testbench

- Parametrised, multi-lane serial CRC engine for the SD host datapath.
- Each lane runs an independent MSB-first CRC over the bits clocked in on that lane.
- With LANES=1, CRC_W=7, POLY=7'h09 it serves the CMD line. With CRC_W=16, POLY=16'h1021 it serves the DAT0..DAT3 lines.
- A built-in sequencer either emits the finished CRC serially after the payload (generate mode) or compares the received trailing CRC against the computed one (check mode).

---
 rtl/sd_crc_lanes.sv | 140 ++++++++++++++
 tb/tb_sd_crc_lanes.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes: multi-lane serial CRC engine for the SD host datapath.
// Each lane runs an independent MSB-first CRC over its serial input bits.
// After the payload, the sequencer either shifts the finished CRC out
// serially (generate mode) or compares the received trailing CRC against
// the computed one (check mode).
//   LANES=1, CRC_W=7,  POLY=7'h09    -> CMD line CRC7
//   CRC_W=16, POLY=16'h1021           -> DAT line CRC16
//
// Ports:
//   sdClk        clock, rising edge
//   crcRst       synchronous active-high reset
//   start        clear all lanes to INIT, latch mode, enter CALC
//   mode         0 = generate, 1 = check (sampled on start)
//   dataEn       dataIn valid this cycle
//   dataIn       one payload/CRC bit per lane
//   finish       last payload bit is this cycle or already passed
//   crcOut       lane l in [l*CRC_W +: CRC_W]
//   crcBit       serial CRC bit per lane while crcBitValid
//   crcBitValid  high during TX
//   busy         state != IDLE
//   done         single-cycle completion pulse
//   errLane      per-lane mismatch, sticky until start
//   crcErr       OR of errLane
module sd_crc_lanes #(
  parameter int unsigned      LANES = 1,
  parameter int unsigned      CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic                   sdClk,
  input  logic                   crcRst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   dataEn,
  input  logic [LANES-1:0]       dataIn,
  input  logic                   finish,
  output logic [LANES*CRC_W-1:0] crcOut,
  output logic [LANES-1:0]       crcBit,
  output logic                   crcBitValid,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       errLane,
  output logic                   crcErr
);

  localparam int unsigned CNT_W = $clog2(CRC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CRC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    TX   = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_mode;
  logic [LANES*CRC_W-1:0]   r_crc;
  logic [LANES-1:0]         r_err;

  logic [LANES*CRC_W-1:0]   w_crcNext;
  logic [LANES-1:0]         w_curBit;
  logic                     w_txLast;
  logic                     w_chkLast;

  // Bit crc[CRC_W-1-idx]: shifting left by idx brings it to the MSB, which
  // avoids a subtracted variable index.
  function automatic logic pick_bit(input logic [CRC_W-1:0] v,
                                    input logic [CNT_W-1:0] idx);
    logic [CRC_W-1:0] s;
    s = v << idx;
    return s[CRC_W-1];
  endfunction

  always_comb begin
    w_crcNext = '0;
    w_curBit  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_crcNext[l*CRC_W +: CRC_W] =
        {r_crc[l*CRC_W +: CRC_W-1], 1'b0} ^
        ((dataIn[l] ^ r_crc[l*CRC_W + CRC_W-1]) ? POLY : '0);
      w_curBit[l] = pick_bit(r_crc[l*CRC_W +: CRC_W], r_cnt);
    end
  end

  assign w_txLast  = (r_state == TX)  && (r_cnt == CNT_LAST);
  // In CHK the counter reaches CRC_W after the last accepted bit, so the
  // done cycle already shows the final errLane.
  assign w_chkLast = (r_state == CHK) && (r_cnt == CNT_FULL);

  always_ff @(posedge sdClk) begin
    if (crcRst) begin
      r_state <= IDLE;
      r_crc   <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else if (start) begin
      r_state <= CALC;
      r_crc   <= {LANES{INIT}};
      r_err   <= '0;
      r_cnt   <= '0;
      r_mode  <= mode;
    end else begin
      case (r_state)
        CALC: begin
          if (dataEn) r_crc <= w_crcNext;
          if (finish) begin
            r_state <= r_mode ? CHK : TX;
            r_cnt   <= '0;
          end
        end
        TX: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_txLast) r_state <= IDLE;
        end
        CHK: begin
          if (w_chkLast) begin
            r_state <= IDLE;
          end else if (dataEn) begin
            r_err <= r_err | (dataIn ^ w_curBit);
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign crcOut      = r_crc;
  assign busy        = (r_state != IDLE);
  assign crcBitValid = (r_state == TX);
  assign crcBit      = (r_state == TX) ? w_curBit : '0;
  assign done        = w_txLast || w_chkLast;
  assign errLane     = r_err;
  assign crcErr      = |r_err;

endmodule

// File: tb/tb_sd_crc_lanes.sv
// Self-checking bench for sd_crc_lanes: one CMD-style instance (1 lane,
// CRC7) and one 4-lane DAT-style instance (CRC16). A polynomial-remainder
// model tracks each instance; a single negedge process compares every
// output every cycle, and literal values pin the model to known CRCs.
module tb_sd_crc_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       crcRst = 1'b1;
  logic       s_start[2] = '{1'b0, 1'b0};
  logic       s_mode[2]  = '{1'b0, 1'b0};
  logic       s_en[2]    = '{1'b0, 1'b0};
  logic       s_fin[2]   = '{1'b0, 1'b0};
  logic [3:0] s_in[2]    = '{4'h0, 4'h0};

  logic [6:0]  c_crc;
  logic [0:0]  c_bit, c_err;
  logic        c_val, c_busy, c_done, c_ce;
  logic [63:0] d_crc;
  logic [3:0]  d_bit, d_err;
  logic        d_val, d_busy, d_done, d_ce;

  sd_crc_lanes #(.LANES(1), .CRC_W(7), .POLY(7'h09), .INIT(7'h00)) u_cmd (
    .sdClk(clk), .crcRst(crcRst), .start(s_start[0]), .mode(s_mode[0]),
    .dataEn(s_en[0]), .dataIn(s_in[0][0:0]), .finish(s_fin[0]),
    .crcOut(c_crc), .crcBit(c_bit), .crcBitValid(c_val), .busy(c_busy),
    .done(c_done), .errLane(c_err), .crcErr(c_ce));

  sd_crc_lanes #(.LANES(4), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) u_dat (
    .sdClk(clk), .crcRst(crcRst), .start(s_start[1]), .mode(s_mode[1]),
    .dataEn(s_en[1]), .dataIn(s_in[1]), .finish(s_fin[1]),
    .crcOut(d_crc), .crcBit(d_bit), .crcBitValid(d_val), .busy(d_busy),
    .done(d_done), .errLane(d_err), .crcErr(d_ce));

  int nChk = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wOf(input int d);   return (d != 0) ? 16 : 7; endfunction
  function automatic int lOf(input int d);   return (d != 0) ? 4 : 1;  endfunction
  function automatic int unsigned gOf(input int d);
    return (d != 0) ? 32'h11021 : 32'h89;
  endfunction

  // rm holds M(x) mod G(x); absorbing bit b gives (M*x + b) mod G.
  function automatic int unsigned absorb(input int unsigned rm, input bit b, input int d);
    int unsigned r;
    r = (rm << 1) | {31'b0, b};
    if (((r >> wOf(d)) & 1) != 0) r = r ^ gOf(d);
    return r;
  endfunction

  // CRC with zero preset = M(x) * x^W mod G(x).
  function automatic int unsigned mulxw(input int unsigned rm, input int d);
    int unsigned r = rm;
    for (int i = 0; i < wOf(d); i++) r = absorb(r, 1'b0, d);
    return r;
  endfunction

  bit          st[2][4][4096];
  bit          rnd3[4096];

  function automatic logic [15:0] model_crc(input int d, input int l, input int n);
    int unsigned rm = 0;
    for (int i = 0; i < n; i++) rm = absorb(rm, st[d][l][i], d);
    return 16'(mulxw(rm, d));
  endfunction

  // phase: 0 idle, 1 calc, 2 tx, 3 chk
  int          m_ph[2];
  int          m_k[2];
  bit          m_mode[2];
  int unsigned m_rm[2][4];
  bit          m_err[2][4];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (crcRst) begin
        m_ph[d] = 0; m_k[d] = 0; m_mode[d] = 1'b0;
        for (int l = 0; l < 4; l++) begin m_rm[d][l] = 0; m_err[d][l] = 1'b0; end
        m_valid = 1'b1;
      end else if (s_start[d]) begin
        m_ph[d] = 1; m_k[d] = 0; m_mode[d] = s_mode[d];
        for (int l = 0; l < 4; l++) begin m_rm[d][l] = 0; m_err[d][l] = 1'b0; end
      end else if (m_ph[d] == 1) begin
        if (s_en[d])
          for (int l = 0; l < lOf(d); l++) m_rm[d][l] = absorb(m_rm[d][l], s_in[d][l], d);
        if (s_fin[d]) begin m_ph[d] = m_mode[d] ? 3 : 2; m_k[d] = 0; end
      end else if (m_ph[d] == 2) begin
        if (m_k[d] == wOf(d) - 1) m_ph[d] = 0;
        m_k[d]++;
      end else if (m_ph[d] == 3) begin
        if (m_k[d] == wOf(d)) m_ph[d] = 0;
        else if (s_en[d]) begin
          for (int l = 0; l < lOf(d); l++)
            if (s_in[d][l] != (((mulxw(m_rm[d][l], d) >> (wOf(d) - 1 - m_k[d])) & 1) != 0))
              m_err[d][l] = 1'b1;
          m_k[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        logic [63:0] aC, eC;
        logic [3:0]  aB, eB, aE, eE;
        logic        aV, aBu, aD, aCE, eD;
        int unsigned cr;
        if (d == 0) begin
          aC = {57'b0, c_crc}; aB = {3'b0, c_bit}; aE = {3'b0, c_err};
          aV = c_val; aBu = c_busy; aD = c_done; aCE = c_ce;
        end else begin
          aC = d_crc; aB = d_bit; aE = d_err;
          aV = d_val; aBu = d_busy; aD = d_done; aCE = d_ce;
        end
        eC = '0; eB = '0; eE = '0;
        for (int l = 0; l < lOf(d); l++) begin
          cr = mulxw(m_rm[d][l], d);
          eC = eC | (64'(cr) << (l * wOf(d)));
          if (m_ph[d] == 2) eB[l] = (((cr >> (wOf(d) - 1 - m_k[d])) & 1) != 0);
          eE[l] = m_err[d][l];
        end
        eD = (m_ph[d] == 2 && m_k[d] == wOf(d) - 1) || (m_ph[d] == 3 && m_k[d] == wOf(d));
        chk($sformatf("u%0d_crcOut", d), aC, eC);
        chk($sformatf("u%0d_crcBit", d), 64'(aB), 64'(eB));
        chk($sformatf("u%0d_crcBitValid", d), 64'(aV), 64'(m_ph[d] == 2));
        chk($sformatf("u%0d_busy", d), 64'(aBu), 64'(m_ph[d] != 0));
        chk($sformatf("u%0d_done", d), 64'(aD), 64'(eD));
        chk($sformatf("u%0d_errLane", d), 64'(aE), 64'(eE));
        chk($sformatf("u%0d_crcErr", d), 64'(aCE), 64'(eE != 4'h0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int d, input int pct);
    for (int g = 0; g < 3 && int'($urandom_range(99)) < pct; g++) begin
      s_en[d] = 1'b0;
      tick();
    end
  endtask

  task automatic run_payload(input int d, input int n, input bit chkMode,
                             input int pct, input bit finLast);
    s_start[d] = 1'b1; s_mode[d] = chkMode;
    tick();
    s_start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap(d, pct);
      s_en[d] = 1'b1;
      for (int l = 0; l < 4; l++) s_in[d][l] = st[d][l][i];
      s_fin[d] = finLast && (i == n - 1);
      tick();
    end
    s_en[d] = 1'b0; s_in[d] = '0;
    if (!finLast) begin
      gap(d, pct);
      s_fin[d] = 1'b1;
      tick();
    end
    s_fin[d] = 1'b0;
  endtask

  task automatic send_trailer(input int d, input logic [15:0] trl[4],
                              input int cnt, input int pct);
    for (int j = 0; j < cnt; j++) begin
      gap(d, pct);
      s_en[d] = 1'b1;
      for (int l = 0; l < 4; l++) s_in[d][l] = trl[l][wOf(d) - 1 - j];
      tick();
    end
    s_en[d] = 1'b0; s_in[d] = '0;
  endtask

  task automatic wait_done(input int d, input int lim);
    int c = 0;
    logic dn;
    do begin
      @(negedge clk);
      c++;
      dn = (d != 0) ? d_done : c_done;
    end while (!dn && c < lim);
    chk($sformatf("u%0d_done_seen", d), 64'(dn), 64'd1);
  endtask

  task automatic load_cmd(input logic [39:0] p);
    for (int i = 0; i < 40; i++) st[0][0][i] = p[39 - i];
  endtask

  task automatic load_dat();
    for (int i = 0; i < 4096; i++) begin
      st[1][0][i] = 1'b1;
      st[1][1][i] = 1'b0;
      st[1][2][i] = (i % 2 == 0);
      st[1][3][i] = rnd3[i];
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] trl[4];
    logic [6:0]  seq;

    for (int i = 0; i < 4096; i++) rnd3[i] = 1'($urandom_range(1));
    repeat (3) tick();
    crcRst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_crcOut", 64'(c_crc), 64'h0);
    chk("rst_dat_busy", 64'(d_busy), 64'h0);
    chk("rst_dat_errLane", 64'(d_err), 64'h0);
    @(posedge clk); #1;

    // CMD0: bits of 7'h4A MSB first, done on the 7th TX cycle
    load_cmd(40'h4000000000);
    run_payload(0, 40, 1'b0, 0, 1'b1);
    seq = 7'h4A;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j == 0) chk("cmd0_crcOut", 64'(c_crc), 64'h4A);
      chk($sformatf("cmd0_bit%0d", j), 64'(c_bit), 64'(seq[6 - j]));
      chk($sformatf("cmd0_done%0d", j), 64'(c_done), 64'(j == 6));
      @(posedge clk); #1;
    end

    load_cmd(40'h5100000000);
    run_payload(0, 40, 1'b0, 30, 1'b0);
    wait_done(0, 20);
    chk("cmd17_crcOut", 64'(c_crc), 64'h2A);

    load_cmd(40'h1100000900);
    run_payload(0, 40, 1'b0, 0, 1'b0);
    wait_done(0, 20);
    chk("resp_crcOut", 64'(c_crc), 64'h33);

    // CMD check mode: good trailer, then one flipped bit
    load_cmd(40'h5100000000);
    trl = '{16'h002A, 16'h0, 16'h0, 16'h0};
    run_payload(0, 40, 1'b1, 20, 1'b1);
    send_trailer(0, trl, 7, 20);
    wait_done(0, 10);
    chk("cmdchk_ok_err", 64'(c_err), 64'h0);
    chk("cmdchk_ok_crcErr", 64'(c_ce), 64'h0);
    @(posedge clk); #1;
    trl[0] = 16'h002B;
    run_payload(0, 40, 1'b1, 0, 1'b1);
    send_trailer(0, trl, 7, 0);
    wait_done(0, 10);
    chk("cmdchk_bad_err", 64'(c_err), 64'h1);
    chk("cmdchk_bad_crcErr", 64'(c_ce), 64'h1);
    @(posedge clk); #1;

    // reset in the middle of a check
    load_cmd(40'h4000000000);
    trl[0] = 16'h0000;
    run_payload(0, 40, 1'b1, 0, 1'b1);
    send_trailer(0, trl, 3, 0);
    crcRst = 1'b1;
    tick();
    crcRst = 1'b0;
    @(negedge clk);
    chk("rstchk_crcOut", 64'(c_crc), 64'h0);
    chk("rstchk_busy", 64'(c_busy), 64'h0);
    chk("rstchk_err", 64'(c_err), 64'h0);
    @(posedge clk); #1;
    s_en[0] = 1'b1; s_in[0] = 4'h1; s_fin[0] = 1'b1;
    repeat (5) tick();
    s_en[0] = 1'b0; s_in[0] = 4'h0; s_fin[0] = 1'b0;
    @(negedge clk);
    chk("rstidle_crcOut", 64'(c_crc), 64'h0);
    chk("rstidle_busy", 64'(c_busy), 64'h0);
    @(posedge clk); #1;

    // 4-lane CRC16 runs
    load_dat();
    chk("model_ones_7FA1", 64'(model_crc(1, 0, 4096)), 64'h7FA1);
    run_payload(1, 4096, 1'b0, 0, 1'b1);
    wait_done(1, 40);
    chk("dat_lane0", 64'(d_crc[15:0]), 64'h7FA1);
    chk("dat_lane1", 64'(d_crc[31:16]), 64'h0);

    run_payload(1, 4096, 1'b0, 25, 1'b0);
    wait_done(1, 40);
    chk("datgap_lane0", 64'(d_crc[15:0]), 64'h7FA1);
    chk("datgap_lane1", 64'(d_crc[31:16]), 64'h0);
    @(posedge clk); #1;

    for (int l = 0; l < 4; l++) trl[l] = model_crc(1, l, 4096);
    run_payload(1, 4096, 1'b1, 0, 1'b1);
    send_trailer(1, trl, 16, 0);
    wait_done(1, 10);
    chk("datchk_ok_err", 64'(d_err), 64'h0);
    chk("datchk_ok_crcErr", 64'(d_ce), 64'h0);
    @(posedge clk); #1;

    trl[2] = trl[2] ^ 16'h0100;
    run_payload(1, 4096, 1'b1, 20, 1'b0);
    send_trailer(1, trl, 16, 20);
    wait_done(1, 10);
    chk("datchk_l2_err", 64'(d_err), 64'h4);
    chk("datchk_l2_crcErr", 64'(d_ce), 64'h1);
    @(posedge clk); #1;

    for (int l = 0; l < 4; l++) trl[l] = model_crc(1, l, 4096);
    trl[0] = 16'h7FA0;
    run_payload(1, 4096, 1'b1, 0, 1'b1);
    send_trailer(1, trl, 16, 0);
    wait_done(1, 10);
    chk("datchk_l0_err", 64'(d_err), 64'h1);
    chk("datchk_l0_crcErr", 64'(d_ce), 64'h1);
    @(posedge clk); #1;

    // start in the middle of TX, then finish with no payload
    run_payload(1, 20, 1'b0, 0, 1'b1);
    repeat (5) tick();
    s_start[1] = 1'b1; s_mode[1] = 1'b0; s_en[1] = 1'b1; s_in[1] = 4'hF;
    tick();
    s_start[1] = 1'b0; s_en[1] = 1'b0; s_in[1] = 4'h0;
    @(negedge clk);
    chk("restart_valid", 64'(d_val), 64'h0);
    chk("restart_crcOut", d_crc, 64'h0);
    chk("restart_done", 64'(d_done), 64'h0);
    chk("restart_busy", 64'(d_busy), 64'h1);
    @(posedge clk); #1;
    s_fin[1] = 1'b1;
    tick();
    s_fin[1] = 1'b0;
    @(negedge clk);
    chk("empty_valid", 64'(d_val), 64'h1);
    wait_done(1, 40);
    chk("empty_crcOut", d_crc, 64'h0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
